// File: rtl/audio_buffer_ctrl_if.sv
// Signal bundle between the double-buffer read controller and its environment:
// the playback controls, the writer handshake, the RAM read port and the sample outputs.
interface audio_buffer_ctrl_if #(
  parameter int unsigned BUFFER_ADDR_BITS = 9
);
  logic                        play_en;
  logic [7:0]                  wav_channels;
  logic                        audio_buffer_filled_i;
  logic                        sample_req;
  logic [7:0]                  ram_rd_data;
  logic                        buffer_active_sel;
  logic [BUFFER_ADDR_BITS-1:0] buffer_rd_address;
  logic                        audio_buffer_empty_o;
  logic [15:0]                 sample_left;
  logic [15:0]                 sample_right;
  logic                        sample_valid;
  logic                        playing_o;
  logic                        underrun_o;

  // Controller side.
  modport master (
    input  play_en, wav_channels, audio_buffer_filled_i, sample_req, ram_rd_data,
    output buffer_active_sel, buffer_rd_address, audio_buffer_empty_o,
           sample_left, sample_right, sample_valid, playing_o, underrun_o
  );

  // Writer / DAC / RAM side.
  modport slave (
    output play_en, wav_channels, audio_buffer_filled_i, sample_req, ram_rd_data,
    input  buffer_active_sel, buffer_rd_address, audio_buffer_empty_o,
           sample_left, sample_right, sample_valid, playing_o, underrun_o
  );
endinterface

// File: rtl/audio_buffer_ctrl.sv
// Ping-pong audio buffer reader: plays one RAM half while the writer fills the other,
// assembles 16-bit PCM frames (mono or stereo) from bytes on request, and swaps halves
// when the active one is exhausted, flagging a sticky underrun if no fresh half is ready.
module audio_buffer_ctrl #(
  parameter int unsigned BUFFER_ADDR_BITS = 9
) (
  input logic                 clk,
  input logic                 rst,
  audio_buffer_ctrl_if.master bus
);

  typedef enum logic [1:0] {StWaitFill, StWaitReq, StFetch, StSwap} state_e;

  state_e                      state_q;
  logic                        sel_q;
  logic                        pending_q;
  logic                        playing_q;
  logic                        underrun_q;
  logic                        valid_q;
  logic                        mono_q;
  logic [BUFFER_ADDR_BITS-1:0] addr_q;
  logic [15:0]                 left_q;
  logic [15:0]                 right_q;
  logic [7:0]                  b0_q;
  logic [7:0]                  b1_q;
  logic [7:0]                  b2_q;
  logic [2:0]                  cnt_q;

  logic [2:0] frame_len;
  logic       fill_avail;

  assign frame_len  = mono_q ? 3'd2 : 3'd4;
  // A filled pulse in the same cycle counts as a ready half.
  assign fill_avail = pending_q | bus.audio_buffer_filled_i;

  assign bus.buffer_active_sel    = sel_q;
  assign bus.buffer_rd_address    = addr_q;
  assign bus.audio_buffer_empty_o = ~pending_q;
  assign bus.sample_left          = left_q;
  assign bus.sample_right         = right_q;
  assign bus.sample_valid         = valid_q;
  assign bus.playing_o            = playing_q;
  assign bus.underrun_o           = underrun_q;

  // Control FSM with all outputs registered.
  // In FETCH, cnt_q counts cycles: addresses are issued while cnt_q < N, byte k arrives
  // while cnt_q == k+1 (one-cycle RAM latency), and the last byte is used directly.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= StWaitFill;
      sel_q      <= 1'b0;
      pending_q  <= 1'b0;
      playing_q  <= 1'b0;
      underrun_q <= 1'b0;
      valid_q    <= 1'b0;
      mono_q     <= 1'b0;
      addr_q     <= '0;
      left_q     <= '0;
      right_q    <= '0;
      b0_q       <= '0;
      b1_q       <= '0;
      b2_q       <= '0;
      cnt_q      <= '0;
    end else begin
      valid_q <= 1'b0;
      if (bus.audio_buffer_filled_i) pending_q <= 1'b1;
      unique case (state_q)
        StWaitFill: begin
          if (bus.sample_req) begin
            valid_q <= 1'b1;
            left_q  <= '0;
            right_q <= '0;
          end
          if (fill_avail) begin
            sel_q     <= ~sel_q;
            pending_q <= 1'b0;
            addr_q    <= '0;
            playing_q <= 1'b1;
            state_q   <= StWaitReq;
          end
        end
        StWaitReq: begin
          if (bus.sample_req) begin
            if (bus.play_en) begin
              state_q <= StFetch;
              cnt_q   <= '0;
              mono_q  <= (bus.wav_channels == 8'd1);
            end else begin
              valid_q <= 1'b1;
              left_q  <= '0;
              right_q <= '0;
            end
          end
        end
        StFetch: begin
          cnt_q <= cnt_q + 3'd1;
          if (cnt_q < frame_len) addr_q <= addr_q + 1'b1;
          if (cnt_q == frame_len) begin
            valid_q <= 1'b1;
            if (mono_q) begin
              left_q  <= {bus.ram_rd_data, b0_q};
              right_q <= {bus.ram_rd_data, b0_q};
            end else begin
              left_q  <= {b1_q, b0_q};
              right_q <= {bus.ram_rd_data, b2_q};
            end
            // Address wrapped to zero means the frame consumed the last byte of the half.
            state_q <= (addr_q == '0) ? StSwap : StWaitReq;
          end else begin
            case (cnt_q)
              3'd1:    b0_q <= bus.ram_rd_data;
              3'd2:    b1_q <= bus.ram_rd_data;
              3'd3:    b2_q <= bus.ram_rd_data;
              default: ;
            endcase
          end
        end
        StSwap: begin
          if (fill_avail) begin
            sel_q     <= ~sel_q;
            pending_q <= 1'b0;
            addr_q    <= '0;
            state_q   <= StWaitReq;
          end else begin
            underrun_q <= 1'b1;
            playing_q  <= 1'b0;
            state_q    <= StWaitFill;
          end
        end
        default: state_q <= StWaitFill;
      endcase
    end
  end

endmodule

// File: tb/tb_audio_buffer_ctrl.sv
// Directed bench for audio_buffer_ctrl with 16-byte buffer halves.
module tb_audio_buffer_ctrl;
  localparam int unsigned AB = 4;

  logic        clk = 1'b0;
  logic        rst;
  int unsigned vec_count = 0;
  int unsigned err_count = 0;
  logic [7:0]  mem [0:31];

  audio_buffer_ctrl_if #(.BUFFER_ADDR_BITS(AB)) bus ();

  audio_buffer_ctrl #(.BUFFER_ADDR_BITS(AB)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  // Synchronous RAM: data valid one cycle after the address.
  always @(posedge clk) bus.ram_rd_data <= mem[{bus.buffer_active_sel, bus.buffer_rd_address}];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic reset_dut();
    rst = 1'b1;
    bus.sample_req = 1'b0;
    bus.audio_buffer_filled_i = 1'b0;
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic fill_pulse();
    bus.audio_buffer_filled_i = 1'b1;
    tick();
    bus.audio_buffer_filled_i = 1'b0;
  endtask

  // Issue one request; lat = cycles from the sampling edge until sample_valid (bounded).
  task automatic run_frame(output int lat);
    bus.sample_req = 1'b1;
    tick();
    bus.sample_req = 1'b0;
    lat = 1;
    while (!bus.sample_valid && lat < 20) begin
      tick();
      lat++;
    end
  endtask

  task automatic test_reset();
    reset_dut();
    vec_count++;
    if ({bus.buffer_active_sel, bus.buffer_rd_address, bus.audio_buffer_empty_o,
         bus.playing_o, bus.underrun_o, bus.sample_valid, bus.sample_left, bus.sample_right}
        !== {1'b0, 4'd0, 1'b1, 1'b0, 1'b0, 1'b0, 32'd0}) begin
      err_count++;
      $display("FAIL reset_state: got %h expected %h",
               {bus.buffer_active_sel, bus.buffer_rd_address, bus.audio_buffer_empty_o,
                bus.playing_o, bus.underrun_o, bus.sample_valid},
               {1'b0, 4'd0, 1'b1, 1'b0, 1'b0, 1'b0});
    end
  endtask

  task automatic test_silence_idle();
    int lat;
    run_frame(lat);
    vec_count++;
    if ({lat, bus.sample_left, bus.sample_right} !== {32'd1, 32'd0}) begin
      err_count++;
      $display("FAIL idle_silence: got lat=%0d L=%h R=%h expected lat=1 L=0 R=0",
               lat, bus.sample_left, bus.sample_right);
    end
    tick();
    vec_count++;
    if ({bus.sample_valid, bus.playing_o, bus.buffer_active_sel} !== 3'b000) begin
      err_count++;
      $display("FAIL idle_after: got %b expected 000",
               {bus.sample_valid, bus.playing_o, bus.buffer_active_sel});
    end
  endtask

  task automatic test_fill();
    fill_pulse();
    vec_count++;
    if ({bus.buffer_active_sel, bus.buffer_rd_address, bus.audio_buffer_empty_o,
         bus.playing_o, bus.underrun_o} !== {1'b1, 4'd0, 1'b1, 1'b1, 1'b0}) begin
      err_count++;
      $display("FAIL fill_swap: got %b expected %b",
               {bus.buffer_active_sel, bus.buffer_rd_address, bus.audio_buffer_empty_o,
                bus.playing_o, bus.underrun_o}, {1'b1, 4'd0, 1'b1, 1'b1, 1'b0});
    end
  endtask

  task automatic test_stereo();
    int lat;
    logic [31:0] held;
    bus.play_en = 1'b1;
    bus.wav_channels = 8'd2;
    run_frame(lat);
    vec_count++;
    if (lat != 6) begin
      err_count++;
      $display("FAIL stereo_latency: got %0d expected 6", lat);
    end
    vec_count++;
    if ({bus.sample_left, bus.sample_right, bus.buffer_rd_address}
        !== {16'h1234, 16'hABCD, 4'd4}) begin
      err_count++;
      $display("FAIL stereo_data: got L=%h R=%h A=%0d expected L=1234 R=abcd A=4",
               bus.sample_left, bus.sample_right, bus.buffer_rd_address);
    end
    held = {bus.sample_left, bus.sample_right};
    tick();
    vec_count++;
    if ({bus.sample_valid, bus.sample_left, bus.sample_right} !== {1'b0, 32'h1234ABCD}) begin
      err_count++;
      $display("FAIL stereo_hold: got v=%b %h expected v=0 %h",
               bus.sample_valid, {bus.sample_left, bus.sample_right}, held);
    end
  endtask

  task automatic test_pause();
    int lat;
    bus.play_en = 1'b0;
    run_frame(lat);
    vec_count++;
    if ({lat, bus.sample_left, bus.sample_right, bus.buffer_rd_address}
        !== {32'd1, 32'd0, 4'd4}) begin
      err_count++;
      $display("FAIL pause_silence: got lat=%0d L=%h R=%h A=%0d expected lat=1 L=0 R=0 A=4",
               lat, bus.sample_left, bus.sample_right, bus.buffer_rd_address);
    end
    bus.play_en = 1'b1;
  endtask

  task automatic test_channel_latch();
    int lat;
    int extra;
    bus.wav_channels = 8'd2;
    bus.sample_req = 1'b1;
    tick();
    bus.sample_req = 1'b0;
    bus.wav_channels = 8'd1;
    tick();
    bus.sample_req = 1'b1;
    tick();
    bus.sample_req = 1'b0;
    lat = 3;
    while (!bus.sample_valid && lat < 20) begin
      tick();
      lat++;
    end
    vec_count++;
    if ({lat, bus.sample_left, bus.sample_right, bus.buffer_rd_address}
        !== {32'd6, 16'h2211, 16'h4433, 4'd8}) begin
      err_count++;
      $display("FAIL channel_latch: got lat=%0d L=%h R=%h A=%0d expected lat=6 L=2211 R=4433 A=8",
               lat, bus.sample_left, bus.sample_right, bus.buffer_rd_address);
    end
    extra = 0;
    for (int i = 0; i < 8; i++) begin
      tick();
      if (bus.sample_valid) extra++;
    end
    vec_count++;
    if (extra != 0) begin
      err_count++;
      $display("FAIL req_in_fetch: got %0d extra strobes expected 0", extra);
    end
    bus.wav_channels = 8'd2;
  endtask

  task automatic test_underrun();
    int lat;
    for (int f = 0; f < 2; f++) begin
      run_frame(lat);
      vec_count++;
      if (lat != 6) begin
        err_count++;
        $display("FAIL underrun_frame%0d: got lat=%0d expected 6", f, lat);
      end
    end
    tick();
    vec_count++;
    if ({bus.playing_o, bus.underrun_o, bus.buffer_rd_address, bus.buffer_active_sel,
         bus.audio_buffer_empty_o} !== {1'b0, 1'b1, 4'd0, 1'b1, 1'b1}) begin
      err_count++;
      $display("FAIL underrun_state: got %b expected %b",
               {bus.playing_o, bus.underrun_o, bus.buffer_rd_address, bus.buffer_active_sel,
                bus.audio_buffer_empty_o}, {1'b0, 1'b1, 4'd0, 1'b1, 1'b1});
    end
    run_frame(lat);
    vec_count++;
    if ({lat, bus.sample_left, bus.sample_right} !== {32'd1, 32'd0}) begin
      err_count++;
      $display("FAIL underrun_silence: got lat=%0d L=%h R=%h expected lat=1 L=0 R=0",
               lat, bus.sample_left, bus.sample_right);
    end
  endtask

  task automatic test_mono();
    int lat;
    mem[16] = 8'hFF;
    mem[17] = 8'h7F;
    reset_dut();
    fill_pulse();
    bus.play_en = 1'b1;
    bus.wav_channels = 8'd1;
    run_frame(lat);
    vec_count++;
    if ({lat, bus.sample_left, bus.sample_right, bus.buffer_rd_address}
        !== {32'd4, 16'h7FFF, 16'h7FFF, 4'd2}) begin
      err_count++;
      $display("FAIL mono_frame: got lat=%0d L=%h R=%h A=%0d expected lat=4 L=7fff R=7fff A=2",
               lat, bus.sample_left, bus.sample_right, bus.buffer_rd_address);
    end
    bus.wav_channels = 8'd2;
  endtask

  task automatic test_swap_fill();
    int lat;
    int bad;
    reset_dut();
    fill_pulse();
    bus.play_en = 1'b1;
    bus.wav_channels = 8'd2;
    bad = 0;
    for (int f = 0; f < 4; f++) begin
      run_frame(lat);
      if (lat != 6) bad++;
    end
    // Final frame's strobe cycle is the SWAP cycle.
    bus.audio_buffer_filled_i = 1'b1;
    tick();
    bus.audio_buffer_filled_i = 1'b0;
    vec_count++;
    if ({bad, bus.buffer_active_sel, bus.buffer_rd_address, bus.audio_buffer_empty_o,
         bus.playing_o, bus.underrun_o} !== {32'd0, 1'b0, 4'd0, 1'b1, 1'b1, 1'b0}) begin
      err_count++;
      $display("FAIL swap_same_cycle_fill: got bad=%0d %b expected bad=0 %b", bad,
               {bus.buffer_active_sel, bus.buffer_rd_address, bus.audio_buffer_empty_o,
                bus.playing_o, bus.underrun_o}, {1'b0, 4'd0, 1'b1, 1'b1, 1'b0});
    end
    fill_pulse();
    fill_pulse();
    vec_count++;
    if (bus.audio_buffer_empty_o !== 1'b0) begin
      err_count++;
      $display("FAIL double_fill_empty: got %b expected 0", bus.audio_buffer_empty_o);
    end
    for (int f = 0; f < 4; f++) run_frame(lat);
    tick();
    vec_count++;
    if ({bus.buffer_active_sel, bus.audio_buffer_empty_o, bus.underrun_o, bus.playing_o}
        !== 4'b1101) begin
      err_count++;
      $display("FAIL pending_swap: got %b expected 1101",
               {bus.buffer_active_sel, bus.audio_buffer_empty_o, bus.underrun_o, bus.playing_o});
    end
    // Only one fill was queued, so the next exhausted half underruns.
    for (int f = 0; f < 4; f++) run_frame(lat);
    tick();
    vec_count++;
    if ({bus.underrun_o, bus.playing_o} !== 2'b10) begin
      err_count++;
      $display("FAIL second_fill_ignored: got %b expected 10", {bus.underrun_o, bus.playing_o});
    end
  endtask

  task automatic test_reset_mid_fetch();
    int lat;
    int strobes;
    mem[16] = 8'h34;
    mem[17] = 8'h12;
    mem[18] = 8'hCD;
    mem[19] = 8'hAB;
    reset_dut();
    fill_pulse();
    bus.play_en = 1'b1;
    bus.wav_channels = 8'd2;
    run_frame(lat);
    vec_count++;
    if ({lat, bus.sample_left} !== {32'd6, 16'h1234}) begin
      err_count++;
      $display("FAIL pre_reset_frame: got lat=%0d L=%h expected lat=6 L=1234", lat, bus.sample_left);
    end
    bus.sample_req = 1'b1;
    tick();
    bus.sample_req = 1'b0;
    bus.audio_buffer_filled_i = 1'b1;
    tick();
    bus.audio_buffer_filled_i = 1'b0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    vec_count++;
    if ({bus.buffer_active_sel, bus.buffer_rd_address, bus.audio_buffer_empty_o,
         bus.sample_valid, bus.playing_o, bus.underrun_o, bus.sample_left, bus.sample_right}
        !== {1'b0, 4'd0, 1'b1, 1'b0, 1'b0, 1'b0, 32'd0}) begin
      err_count++;
      $display("FAIL mid_fetch_reset: got %b L=%h R=%h expected 000001000 L=0 R=0",
               {bus.buffer_active_sel, bus.buffer_rd_address, bus.audio_buffer_empty_o,
                bus.sample_valid, bus.playing_o, bus.underrun_o},
               bus.sample_left, bus.sample_right);
    end
    strobes = 0;
    for (int i = 0; i < 8; i++) begin
      tick();
      if (bus.sample_valid) strobes++;
    end
    vec_count++;
    if ({strobes, bus.buffer_active_sel} !== {32'd0, 1'b0}) begin
      err_count++;
      $display("FAIL abandoned_frame: got strobes=%0d sel=%b expected strobes=0 sel=0",
               strobes, bus.buffer_active_sel);
    end
  endtask

  initial begin
    for (int i = 0; i < 32; i++) mem[i] = 8'(i);
    mem[16] = 8'h34;
    mem[17] = 8'h12;
    mem[18] = 8'hCD;
    mem[19] = 8'hAB;
    mem[20] = 8'h11;
    mem[21] = 8'h22;
    mem[22] = 8'h33;
    mem[23] = 8'h44;
    rst = 1'b1;
    bus.play_en = 1'b0;
    bus.wav_channels = 8'd2;
    bus.audio_buffer_filled_i = 1'b0;
    bus.sample_req = 1'b0;

    test_reset();
    test_silence_idle();
    test_fill();
    test_stereo();
    test_pause();
    test_channel_latch();
    test_underrun();
    test_mono();
    test_swap_fill();
    test_reset_mid_fetch();

    $display("== %0d vectors applied, %0d miscompares ==", vec_count, err_count);
    $finish;
  end

endmodule
